// File: rtl/game_pkg.sv
// game_pkg: state encoding, BCD limits, timing defaults and the mm:ss increment
// shared by the game timer blocks.
package game_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, STOPPED = 2'd3} state_t;
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;
    localparam int DEF_TICK_MOD = 50_000_000;
    localparam int DEF_BLINK_MOD = 25_000_000;
    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;
    localparam bcd_time_t TIME_MAX = {BCD_NINE, BCD_NINE, BCD_FIVE, BCD_NINE};
    // Ripple carry through the digits; min_tens has no carry out.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec_ones != BCD_NINE) r.sec_ones = t.sec_ones + 4'd1;
        else begin
            r.sec_ones = 4'd0;
            if (t.sec_tens != BCD_FIVE) r.sec_tens = t.sec_tens + 4'd1;
            else begin
                r.sec_tens = 4'd0;
                if (t.min_ones != BCD_NINE) r.min_ones = t.min_ones + 4'd1;
                else begin
                    r.min_ones = 4'd0;
                    r.min_tens = t.min_tens + 4'd1;
                end
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: modulo-MOD counter with enable and synchronous clear; o_wrap flags
// the enabled cycle at the terminal count.
module tick_gen #(
    parameter int NUM_BITS = 26,
    parameter int MOD = 50_000_000
) (
    input  logic clock_in,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_wrap
);
    logic [NUM_BITS-1:0] r_count;
    assign o_wrap = i_en && (r_count == NUM_BITS'(MOD - 1));
    always_ff @(posedge clock_in) begin
        if (reset || i_clr) r_count <= '0;
        else if (i_en) r_count <= o_wrap ? '0 : r_count + NUM_BITS'(1);
    end
endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: Sudoku game timer; 1 Hz tick from a prescaler, BCD mm:ss
// with start/pause/stop/clear, 99:59 saturation and a paused-display blink.
module game_timer_ctrl
    import game_pkg::*;
#(
    parameter int TICK_BITS = 26,
    parameter int TICK_MOD = DEF_TICK_MOD,
    parameter int BLINK_MOD = DEF_BLINK_MOD
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       start,
    input  logic       pause_toggle,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       tick,
    output logic       running,
    output logic       blink,
    output logic       overflow
);
    state_t    r_state;
    bcd_time_t r_time;
    logic      r_tick, r_running, r_blink, r_overflow;
    logic      w_wrap, w_blink_wrap, w_stop, w_start, w_pause, w_sat, w_inc;
    state_t    w_next;

    // Stop in IDLE does nothing, so it does not mask a simultaneous start there.
    assign w_stop  = !clear && stop && (r_state != IDLE);
    assign w_start = !clear && !w_stop && start;
    assign w_pause = !clear && !w_stop && !start && pause_toggle &&
                     (r_state == RUN || r_state == PAUSE);
    assign w_sat   = (r_time == TIME_MAX);
    assign w_inc   = w_wrap && !w_sat && !clear && !w_start;

    always_comb
        w_next = clear ? IDLE :
                 w_stop ? STOPPED :
                 w_start ? RUN :
                 (w_wrap && w_sat) ? STOPPED :
                 w_pause ? ((r_state == RUN) ? PAUSE : RUN) :
                 r_state;

    tick_gen #(.NUM_BITS(TICK_BITS), .MOD(TICK_MOD)) u_prescaler (
        .clock_in(clock_in),
        .reset   (reset),
        .i_en    (r_state == RUN),
        .i_clr   (clear || w_start),
        .o_wrap  (w_wrap)
    );

    tick_gen #(.NUM_BITS(TICK_BITS), .MOD(BLINK_MOD)) u_blink (
        .clock_in(clock_in),
        .reset   (reset),
        .i_en    (r_state == PAUSE),
        .i_clr   (w_next != PAUSE),
        .o_wrap  (w_blink_wrap)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state    <= IDLE;
            r_time     <= '0;
            r_tick     <= 1'b0;
            r_running  <= 1'b0;
            r_blink    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_tick    <= w_inc && (w_next == RUN);
            r_running <= (w_next == RUN);
            r_blink   <= (w_next != PAUSE) || (w_blink_wrap ? !r_blink : r_blink);
            if (clear || w_start) begin
                r_time     <= '0;
                r_overflow <= 1'b0;
            end else if (w_inc) r_time <= bcd_inc(r_time);
            else if (w_wrap && w_sat) r_overflow <= 1'b1;
        end
    end

    assign sec_ones = r_time.sec_ones;
    assign sec_tens = r_time.sec_tens;
    assign min_ones = r_time.min_ones;
    assign min_tens = r_time.min_tens;
    assign tick     = r_tick;
    assign running  = r_running;
    assign blink    = r_blink;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: directed scenarios plus random pulses, checked against a
// seconds-count reference model of the game timer.
module tb_game_timer_ctrl;
    localparam int TM = 4;
    localparam int BM = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_STOP = 3;
    localparam int MAX_SECS = 99 * 60 + 59;

    logic clock_in = 1'b0, reset = 1'b0, start = 1'b0, pause_toggle = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic tick, running, blink, overflow;
    int n_checks = 0, n_pass = 0;
    int m_mode = M_IDLE, m_phase = 0, m_secs = 0, m_pcnt = 0;
    bit m_tick = 1'b0, m_blink = 1'b1, m_ovf = 1'b0;

    game_timer_ctrl #(.TICK_BITS(4), .TICK_MOD(TM), .BLINK_MOD(BM)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .start       (start),
        .pause_toggle(pause_toggle),
        .stop        (stop),
        .clear       (clear),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .min_ones    (min_ones),
        .min_tens    (min_tens),
        .tick        (tick),
        .running     (running),
        .blink       (blink),
        .overflow    (overflow)
    );

    always #5 clock_in = ~clock_in;

    // Reference: elapsed time is a plain seconds count, the partial second a phase count.
    always @(posedge clock_in) begin : model
        int nm;
        bit wrap, inc;
        if (reset) begin
            m_mode = M_IDLE; m_phase = 0; m_secs = 0; m_pcnt = 0;
            m_tick = 1'b0; m_blink = 1'b1; m_ovf = 1'b0;
        end else begin
            wrap = (m_mode == M_RUN) && (m_phase == TM - 1);
            if (m_mode == M_RUN) m_phase = (m_phase + 1) % TM;
            inc = 1'b0;
            nm = m_mode;
            if (clear) begin
                nm = M_IDLE; m_secs = 0; m_phase = 0; m_ovf = 1'b0;
            end else if (stop && m_mode != M_IDLE) begin
                nm = M_STOP;
                if (wrap && m_secs == MAX_SECS) m_ovf = 1'b1;
                else inc = wrap;
            end else if (start) begin
                nm = M_RUN; m_secs = 0; m_phase = 0; m_ovf = 1'b0;
            end else if (wrap && m_secs == MAX_SECS) begin
                nm = M_STOP; m_ovf = 1'b1;
            end else begin
                inc = wrap;
                if (pause_toggle && m_mode == M_RUN) nm = M_PAUSE;
                else if (pause_toggle && m_mode == M_PAUSE) nm = M_RUN;
            end
            if (inc) m_secs = m_secs + 1;
            m_tick = inc && (nm == M_RUN);
            m_pcnt = (nm == M_PAUSE && m_mode == M_PAUSE) ? m_pcnt + 1 : 0;
            m_blink = (nm != M_PAUSE) || ((m_pcnt / BM) % 2 == 0);
            m_mode = nm;
        end
    end

    function automatic logic [19:0] dut_v();
        return {min_tens, min_ones, sec_tens, sec_ones, tick, running, blink, overflow};
    endfunction

    function automatic logic [19:0] mdl_v();
        return {4'(m_secs / 600), 4'((m_secs / 60) % 10), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
                m_tick, m_mode == M_RUN, m_blink, m_ovf};
    endfunction

    task automatic pulse(input logic s, input logic p, input logic t, input logic c, input logic r);
        start = s; pause_toggle = p; stop = t; clear = c; reset = r;
        @(negedge clock_in);
        {start, pause_toggle, stop, clear, reset} = 5'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic test_reset();
        pulse(0, 0, 0, 0, 1);
        n_checks++; if (dut_v() !== 20'h00002) $display("FAIL reset_state got=%h want=%h", dut_v(), 20'h00002); else n_pass++;
        n_checks++; if (dut_v() !== mdl_v()) $display("FAIL reset_model got=%h want=%h", dut_v(), mdl_v()); else n_pass++;
    endtask

    task automatic test_start_tick();
        pulse(1, 0, 0, 0, 0);
        n_checks++; if (dut_v() !== 20'h00006) $display("FAIL start_running got=%h want=%h", dut_v(), 20'h00006); else n_pass++;
        wait_cyc(3);
        n_checks++; if (dut_v() !== 20'h00006) $display("FAIL start_pre_tick got=%h want=%h", dut_v(), 20'h00006); else n_pass++;
        wait_cyc(1);
        n_checks++; if (dut_v() !== 20'h0001E) $display("FAIL first_tick got=%h want=%h", dut_v(), 20'h0001E); else n_pass++;
        wait_cyc(1);
        n_checks++; if (dut_v() !== 20'h00016) $display("FAIL tick_one_cycle got=%h want=%h", dut_v(), 20'h00016); else n_pass++;
        wait_cyc(35);
        n_checks++; if (dut_v()[19:4] !== 16'h0010) $display("FAIL ten_secs got=%h want=%h", dut_v()[19:4], 16'h0010); else n_pass++;
        n_checks++; if (dut_v() !== mdl_v()) $display("FAIL start_model got=%h want=%h", dut_v(), mdl_v()); else n_pass++;
    endtask

    task automatic test_carry();
        pulse(0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0);
        wait_cyc(59 * TM);
        n_checks++; if (dut_v()[19:4] !== 16'h0059) $display("FAIL carry_0059 got=%h want=%h", dut_v()[19:4], 16'h0059); else n_pass++;
        wait_cyc(TM);
        n_checks++; if (dut_v()[19:4] !== 16'h0100) $display("FAIL carry_0100 got=%h want=%h", dut_v()[19:4], 16'h0100); else n_pass++;
        pulse(0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0);
        wait_cyc(599 * TM);
        n_checks++; if (dut_v()[19:4] !== 16'h0959) $display("FAIL carry_0959 got=%h want=%h", dut_v()[19:4], 16'h0959); else n_pass++;
        wait_cyc(TM);
        n_checks++; if (dut_v()[19:4] !== 16'h1000) $display("FAIL carry_1000 got=%h want=%h", dut_v()[19:4], 16'h1000); else n_pass++;
        n_checks++; if (dut_v() !== mdl_v()) $display("FAIL carry_model got=%h want=%h", dut_v(), mdl_v()); else n_pass++;
    endtask

    task automatic test_pause();
        pulse(0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0);
        wait_cyc(2 * TM + 1);
        pulse(0, 1, 0, 0, 0);
        n_checks++; if (dut_v() !== 20'h00022) $display("FAIL pause_enter got=%h want=%h", dut_v(), 20'h00022); else n_pass++;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock_in);
            n_checks++;
            if ({dut_v()[19:4], blink} !== {16'h0002, 1'((i / BM) % 2 == 0)})
                $display("FAIL pause_hold_%0d got=%h/%b want=%h/%b", i, dut_v()[19:4], blink, 16'h0002, 1'((i / BM) % 2 == 0));
            else n_pass++;
        end
        pulse(0, 1, 0, 0, 0);
        n_checks++; if (dut_v() !== 20'h00026) $display("FAIL resume got=%h want=%h", dut_v(), 20'h00026); else n_pass++;
        wait_cyc(1);
        n_checks++; if (dut_v()[19:4] !== 16'h0002) $display("FAIL resume_partial got=%h want=%h", dut_v()[19:4], 16'h0002); else n_pass++;
        wait_cyc(1);
        n_checks++; if (dut_v() !== 20'h0003E) $display("FAIL resume_tick got=%h want=%h", dut_v(), 20'h0003E); else n_pass++;
        n_checks++; if (dut_v() !== mdl_v()) $display("FAIL pause_model got=%h want=%h", dut_v(), mdl_v()); else n_pass++;
    endtask

    task automatic test_saturate();
        pulse(0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0);
        wait_cyc(MAX_SECS * TM);
        n_checks++; if (dut_v()[19:4] !== 16'h9959) $display("FAIL sat_reach got=%h want=%h", dut_v()[19:4], 16'h9959); else n_pass++;
        for (int i = 1; i <= TM; i++) begin
            @(negedge clock_in);
            n_checks++; if (tick !== 1'b0) $display("FAIL sat_no_tick_%0d got=%b want=0", i, tick); else n_pass++;
        end
        n_checks++; if (dut_v() !== 20'h99593) $display("FAIL sat_hold got=%h want=%h", dut_v(), 20'h99593); else n_pass++;
        n_checks++; if (dut_v() !== mdl_v()) $display("FAIL sat_model got=%h want=%h", dut_v(), mdl_v()); else n_pass++;
        pulse(1, 0, 0, 0, 0);
        n_checks++; if (dut_v() !== 20'h00006) $display("FAIL sat_restart got=%h want=%h", dut_v(), 20'h00006); else n_pass++;
    endtask

    task automatic test_stop();
        pulse(0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0);
        wait_cyc(5 * TM);
        pulse(0, 0, 1, 0, 0);
        n_checks++; if (dut_v() !== 20'h00052) $display("FAIL stop_freeze got=%h want=%h", dut_v(), 20'h00052); else n_pass++;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clock_in);
            n_checks++; if (dut_v() !== 20'h00052) $display("FAIL stop_hold_%0d got=%h want=%h", i, dut_v(), 20'h00052); else n_pass++;
        end
        pulse(0, 1, 0, 0, 0);
        n_checks++; if (dut_v() !== 20'h00052) $display("FAIL stop_pause_ign got=%h want=%h", dut_v(), 20'h00052); else n_pass++;
        pulse(0, 0, 0, 1, 0);
        n_checks++; if (dut_v() !== 20'h00002) $display("FAIL stop_clear got=%h want=%h", dut_v(), 20'h00002); else n_pass++;
    endtask

    task automatic test_back_to_back();
        pulse(1, 0, 0, 0, 0);
        wait_cyc(TM - 1);
        pulse(0, 0, 1, 1, 0);
        n_checks++; if (dut_v() !== 20'h00002) $display("FAIL clear_on_wrap got=%h want=%h", dut_v(), 20'h00002); else n_pass++;
        wait_cyc(1);
        n_checks++; if (dut_v() !== 20'h00002) $display("FAIL clear_no_tick got=%h want=%h", dut_v(), 20'h00002); else n_pass++;
        pulse(1, 0, 0, 0, 0);
        wait_cyc(TM + 2);
        pulse(0, 0, 0, 0, 1);
        n_checks++; if (dut_v() !== 20'h00002) $display("FAIL reset_mid_run got=%h want=%h", dut_v(), 20'h00002); else n_pass++;
        n_checks++; if (dut_v() !== mdl_v()) $display("FAIL reset_mid_model got=%h want=%h", dut_v(), mdl_v()); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom_range(0, 23) == 0);
            pause_toggle = ($urandom_range(0, 9) == 0);
            stop         = ($urandom_range(0, 39) == 0);
            clear        = ($urandom_range(0, 59) == 0);
            reset        = ($urandom_range(0, 499) == 0);
            @(negedge clock_in);
            n_checks++; if (dut_v() !== mdl_v()) $display("FAIL random_%0d got=%h want=%h", i, dut_v(), mdl_v()); else n_pass++;
        end
        {start, pause_toggle, stop, clear, reset} = 5'b0;
    endtask

    initial begin
        @(negedge clock_in);
        test_reset();
        test_start_tick();
        test_carry();
        test_pause();
        test_saturate();
        test_stop();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
